// File: rtl/adbg_or1k_pkg.sv
// Shared OR1K debug types: cross-trigger FSM states and the first-hit priority picker.
package adbg_or1k_pkg;

  typedef enum logic {XT_IDLE, XT_HOLD} xt_state_e;

  localparam int XT_MAX_CORES = 32;
  localparam int XT_MAX_IDX_W = 5;

  // Lowest set bit wins; callers zero-extend narrower vectors.
  function automatic logic [XT_MAX_IDX_W-1:0] lowest_set_idx(input logic [XT_MAX_CORES-1:0] v);
    logic [XT_MAX_IDX_W-1:0] r;
    r = '0;
    for (int i = XT_MAX_CORES - 1; i >= 0; i--)
      if (v[i]) r = XT_MAX_IDX_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/adbg_sat_counter.sv
// Saturating up-counter; clear takes priority over a same-cycle increment.
module adbg_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

endmodule

// File: rtl/adbg_or1k_bp_xtrig.sv
// Breakpoint collector: edge-detects per-core halt requests, optionally broadcasts
// a halt across the programmed group, and tracks first hitter plus hit counts.
module adbg_or1k_bp_xtrig
  import adbg_or1k_pkg::*;
#(
  parameter int NB_CORES = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = 2
) (
  input  logic                      cpu_clk_i,
  input  logic                      cpu_rstn_i,
  input  logic [NB_CORES-1:0]       core_bp_i,
  input  logic [NB_CORES-1:0]       group_mask_i,
  input  logic                      halt_all_en_i,
  input  logic [NB_CORES-1:0]       cpu_stall_i,
  input  logic                      cnt_clr_i,
  output logic [NB_CORES-1:0]       bp_o,
  output logic [IDX_W-1:0]          first_hit_idx_o,
  output logic                      first_hit_vld_o,
  output logic [NB_CORES*CNT_W-1:0] hit_cnt_o
);

  logic [NB_CORES-1:0] prev_q, bp_q, rise;
  logic [IDX_W-1:0]    idx_q;
  logic                vld_q;
  logic                xt;
  xt_state_e           state_q;

  assign rise = core_bp_i & ~prev_q;
  assign xt   = halt_all_en_i && |(rise & group_mask_i);

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i)
    if (!cpu_rstn_i) prev_q <= '0;
    else             prev_q <= core_bp_i;

  // Broadcast only on the hit that opens an episode; later hits just pass through.
  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      state_q <= XT_IDLE;
      bp_q    <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        XT_IDLE: begin
          if (rise == '0) begin
            bp_q <= '0;
          end else begin
            bp_q    <= rise | (xt ? group_mask_i : '0);
            idx_q   <= IDX_W'(lowest_set_idx(XT_MAX_CORES'(rise)));
            vld_q   <= 1'b1;
            state_q <= XT_HOLD;
          end
        end
        XT_HOLD: begin
          bp_q <= rise;
          if (cpu_stall_i == '0 && bp_q == '0 && rise == '0) begin
            vld_q   <= 1'b0;
            state_q <= XT_IDLE;
          end
        end
        default: state_q <= XT_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NB_CORES; g++) begin : g_cnt
    adbg_sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i  (cpu_clk_i),
      .rst_ni (cpu_rstn_i),
      .inc_i  (rise[g]),
      .clr_i  (cnt_clr_i),
      .cnt_o  (hit_cnt_o[g*CNT_W +: CNT_W])
    );
  end

  assign bp_o            = bp_q;
  assign first_hit_idx_o = idx_q;
  assign first_hit_vld_o = vld_q;

endmodule

// File: tb/tb_adbg_or1k_bp_xtrig.sv
// Scoreboard bench: a cycle model pushes expected outputs as stimulus is applied,
// popped and compared after each clock edge; directed checks cover the key scenarios.
module tb_adbg_or1k_bp_xtrig;
  localparam int NB = 4;
  localparam int CW = 2;
  localparam int IW = 2;

  logic              clk = 1'b0, rstn = 1'b0;
  logic [NB-1:0]     core_bp = '0, mask = '0, stall = '0;
  logic              en = 1'b0, clr = 1'b0;
  logic [NB-1:0]     bp_o;
  logic [IW-1:0]     idx_o;
  logic              vld_o;
  logic [NB*CW-1:0]  cnt_o;

  always #5 clk = ~clk;

  adbg_or1k_bp_xtrig #(.NB_CORES(NB), .CNT_W(CW), .IDX_W(IW)) dut (
    .cpu_clk_i(clk), .cpu_rstn_i(rstn), .core_bp_i(core_bp), .group_mask_i(mask),
    .halt_all_en_i(en), .cpu_stall_i(stall), .cnt_clr_i(clr), .bp_o(bp_o),
    .first_hit_idx_o(idx_o), .first_hit_vld_o(vld_o), .hit_cnt_o(cnt_o));

  typedef struct packed {
    logic [NB-1:0]    bp;
    logic [IW-1:0]    idx;
    logic             vld;
    logic [NB*CW-1:0] cnt;
  } exp_t;

  exp_t          sbq[$];
  logic [NB-1:0] m_prev, m_bp;
  logic [IW-1:0] m_idx;
  logic          m_vld, m_hold;
  logic [CW-1:0] m_cnt [NB];
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_bp = '0; m_idx = '0; m_vld = 1'b0; m_hold = 1'b0;
    for (int i = 0; i < NB; i++) m_cnt[i] = '0;
    sbq.delete();
  endtask

  function automatic logic [IW-1:0] low_idx(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return IW'(i);
    return '0;
  endfunction

  task automatic predict();
    logic [NB-1:0] rise;
    exp_t e;
    rise = core_bp & ~m_prev;
    for (int i = 0; i < NB; i++)
      if (clr) m_cnt[i] = '0;
      else if (rise[i] && m_cnt[i] != '1) m_cnt[i] = m_cnt[i] + CW'(1);
    if (!m_hold) begin
      if (rise == '0) m_bp = '0;
      else begin
        m_bp   = rise | ((en && |(rise & mask)) ? mask : '0);
        m_idx  = low_idx(rise);
        m_vld  = 1'b1;
        m_hold = 1'b1;
      end
    end else begin
      if (stall == '0 && m_bp == '0 && rise == '0) begin
        m_hold = 1'b0;
        m_vld  = 1'b0;
      end
      m_bp = rise;
    end
    m_prev = core_bp;
    e.bp = m_bp; e.idx = m_idx; e.vld = m_vld;
    for (int i = 0; i < NB; i++) e.cnt[i*CW +: CW] = m_cnt[i];
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    predict();
    @(posedge clk); #1;
    chk("sb_depth", sbq.size(), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("sb_bp", bp_o, e.bp);
      chk("sb_idx", idx_o, e.idx);
      chk("sb_vld", vld_o, e.vld);
      chk("sb_cnt", cnt_o, e.cnt);
    end
  endtask

  task automatic settle();
    core_bp = '0; stall = '0; clr = 1'b0;
    repeat (3) tick();
    chk("settle_vld", vld_o, 0);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_bp", bp_o, 0); chk("rst_idx", idx_o, 0);
    chk("rst_vld", vld_o, 0); chk("rst_cnt", cnt_o, 0);
    rstn = 1'b1;
    tick();

    // single hit
    core_bp = 4'b0100; tick();
    chk("single_bp", bp_o, 4'b0100); chk("single_idx", idx_o, 2); chk("single_vld", vld_o, 1);
    chk("single_cnt2", cnt_o[2*CW +: CW], 1); chk("single_cnt0", cnt_o[0 +: CW], 0);
    tick();
    chk("single_bp_once", bp_o, 0);
    settle();

    // cross-trigger
    mask = 4'b1011; en = 1'b1; core_bp = 4'b0010; tick();
    chk("xt_bp", bp_o, 4'b1011); chk("xt_idx", idx_o, 1);
    chk("xt_cnt1", cnt_o[1*CW +: CW], 1); chk("xt_cnt3", cnt_o[3*CW +: CW], 0);
    chk("xt_cnt0", cnt_o[0 +: CW], 0);
    tick(); chk("xt_bp_once", bp_o, 0);
    settle();

    // trigger outside the group
    mask = 4'b0011; core_bp = 4'b1000; tick();
    chk("out_bp", bp_o, 4'b1000); chk("out_idx", idx_o, 3);
    settle();

    // simultaneous rises, then stall-held episode
    en = 1'b0; core_bp = 4'b1010; tick();
    chk("sim_bp", bp_o, 4'b1010); chk("sim_idx", idx_o, 1);
    stall = 4'b1010;
    repeat (10) tick();
    chk("sim_vld_held", vld_o, 1);
    stall = '0; tick();
    chk("sim_vld_drop", vld_o, 0);
    settle();

    // HOLD pass-through, no broadcast
    en = 1'b1; mask = 4'b0100; core_bp = 4'b0001; tick();
    chk("pass_bp0", bp_o, 4'b0001); chk("pass_idx0", idx_o, 0);
    stall = 4'b0001; core_bp = 4'b0101; tick();
    chk("pass_bp2", bp_o, 4'b0100); chk("pass_idx", idx_o, 0);
    tick(); chk("pass_bp_once", bp_o, 0);
    settle();

    // saturation and clear-beats-increment
    en = 1'b0;
    repeat (5) begin
      core_bp = 4'b0001; tick();
      core_bp = 4'b0000; tick();
    end
    chk("sat_cnt0", cnt_o[0 +: CW], 3);
    clr = 1'b1; core_bp = 4'b0001; tick(); clr = 1'b0;
    chk("clr_cnt0", cnt_o[0 +: CW], 0);
    settle();

    // reset mid-HOLD with request held high
    core_bp = 4'b0001; stall = 4'b0001; tick();
    chk("prerst_vld", vld_o, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_bp", bp_o, 0); chk("arst_vld", vld_o, 0); chk("arst_cnt", cnt_o, 0);
    model_reset();
    @(posedge clk); #1;
    chk("inrst_bp", bp_o, 0);
    #3 rstn = 1'b1;
    stall = '0;
    tick();
    chk("postrst_bp", bp_o, 4'b0001); chk("postrst_idx", idx_o, 0);
    tick();
    chk("postrst_bp_once", bp_o, 0);
    settle();

    // random traffic against the model
    for (int n = 0; n < 60; n++) begin
      core_bp = NB'($urandom);
      mask    = NB'($urandom);
      en      = 1'($urandom);
      stall   = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
      clr     = ($urandom_range(0, 15) == 0);
      tick();
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
